// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared types and defaults for the UART transmit arbiter.
//   arb_state_t  : IDLE (no owner), LOCK (owner set, holding empty),
//                  LOAD (holding byte full, waiting for the transmitter).
//   NREQ_DEF     : default number of byte-stream requesters.
//   TIMEOUT_DEF  : default idle-owner lock timeout in clk cycles.
package uart_tx_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    LOAD = 2'd2
  } arb_state_t;

  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req  [N-1:0]  : request vector
//   ptr  [PW-1:0] : index with highest priority this round
//   pick [N-1:0]  : one-hot first set request at or after ptr (wrapping)
//   any           : at least one request is set
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  // Two passes instead of a modulo: first the indices at or above ptr,
  // then the wrapped-around indices below it.
  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i >= int'(ptr))) begin
        pick[i] = 1'b1;
        any     = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!any && req[i] && (i < int'(ptr))) begin
        pick[i] = 1'b1;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: arbitrates NREQ byte-stream requesters onto one UART
// transmitter. A requester owns the transmitter for a whole message (until
// its last byte has been started), so messages never interleave.
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_data/req_last/req_ready : per-requester byte streams
//   tx_req, tx_data          : holding byte towards the transmitter
//   tx_started               : transmitter latched tx_data (1-cycle pulse)
//   grant                    : one-hot current owner, zero when none
//   busy                     : state is not IDLE
//   state_dbg                : current FSM state for observation
// Build option: define UART_TX_ARB_TIMEOUT_EN to release an owner that sits
// in LOCK without transferring for TIMEOUT cycles.
//
// Handshake: a byte moves from requester i when req_valid[i] and
// req_ready[i] are both high at a rising clk edge; req_ready depends only on
// arbiter state (never on req_valid), and a requester may drop req_valid at
// any time without losing its lock.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic              tx_started,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output arb_state_t        state_dbg
);

  localparam int PW = $clog2(NREQ);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            last_q, last_d;

  logic [NREQ-1:0] pick;
  logic            pick_any;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   next_ptr;
  logic            xfer;
  logic            timeout_hit;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req  (req_valid),
    .ptr  (rr_ptr_q),
    .pick (pick),
    .any  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  // Priority after a released message goes to the requester after the owner.
  assign next_ptr  = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
  assign req_ready = (state_q == LOCK) ? grant_q : '0;
  assign xfer      = |(req_valid & req_ready);

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT);
  logic [CW-1:0] cnt_q, cnt_d;

  assign timeout_hit = (state_q == LOCK) && !xfer && (cnt_q == CW'(TIMEOUT - 1));

  // Counts idle LOCK cycles; every other cycle (including the transfer and
  // the cycles outside LOCK) restarts it, so it is zero on entering LOCK.
  always_comb begin
    cnt_d = '0;
    if ((state_q == LOCK) && !xfer && !timeout_hit) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    rr_ptr_d  = rr_ptr_q;
    tx_data_d = tx_data_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOCK;
          grant_d = pick;
          owner_d = pick_idx;
        end
      end
      LOCK: begin
        if (xfer) begin
          tx_data_d = req_data[{owner_q, 3'b000} +: 8];
          last_d    = req_last[owner_q];
          state_d   = LOAD;
        end else if (timeout_hit) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr;
          grant_d  = '0;
        end
      end
      LOAD: begin
        if (tx_started) begin
          if (last_q) begin
            state_d  = IDLE;
            rr_ptr_d = next_ptr;
            grant_d  = '0;
          end else begin
            state_d = LOCK;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      tx_data_q <= 8'h00;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      tx_data_q <= tx_data_d;
      last_q    <= last_d;
    end
  end

  assign tx_req    = (state_q == LOAD);
  assign tx_data   = tx_data_q;
  assign grant     = grant_q;
  assign busy      = (state_q != IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: self-checking bench for uart_tx_arb (NREQ=4, TIMEOUT=16).
// Reference model: whole messages are served one at a time, each going to
// the first requester with pending data at or after a round-robin pointer.
module tb_uart_tx_arb;
  import uart_tx_arb_pkg::*;

  localparam int N  = 4;
  localparam int TO = 16;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N-1:0]     req_valid, req_last, req_ready, grant;
  logic [8*N-1:0]   req_data;
  logic             tx_req, tx_started, busy;
  logic [7:0]       tx_data;
  arb_state_t       state_dbg;
  logic             auto_pulse, man_pulse;
  bit               tx_auto;

  assign tx_started = auto_pulse | man_pulse;

  uart_tx_arb #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_req(tx_req),
    .tx_data(tx_data), .tx_started(tx_started), .grant(grant),
    .busy(busy), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int         exp_own_q[$];
  int         obs_own_q[$];
  logic [8:0] src_q[N][$];   // {last, data} per requester
  int         total = 0;
  int         bad   = 0;
  int         m_ptr = 0;     // model round-robin pointer

  // Transmitter model: after tx_req, wait a random frame gap and pulse.
  initial begin
    int gap;
    gap = 0;
    auto_pulse = 1'b0;
    forever begin
      @(posedge clk); #1;
      auto_pulse = 1'b0;
      if (tx_auto && tx_req) begin
        if (gap == 0) begin
          auto_pulse = 1'b1;
          got_q.push_back(tx_data);
          gap = $urandom_range(0, 3);
        end else begin
          gap--;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0; req_last = '0; req_data = '0;
    step(); step();
    rst = 1'b0;
    m_ptr = 0;
  endtask

  task automatic pulse_started();
    man_pulse = 1'b1; step(); man_pulse = 1'b0;
  endtask

  task automatic drive_src();
    logic [8:0] e;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        e = src_q[i][0];
        req_valid[i] = 1'b1; req_last[i] = e[8]; req_data[8*i +: 8] = e[7:0];
      end else begin
        req_valid[i] = 1'b0; req_last[i] = 1'b0; req_data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  task automatic build_expected();
    logic [8:0] mq[N][$];
    logic [8:0] e;
    int found, j;
    for (int i = 0; i < N; i++) mq[i] = src_q[i];
    forever begin
      found = -1;
      for (int k = 0; k < N; k++) begin
        j = (m_ptr + k) % N;
        if (found < 0 && mq[j].size() > 0) found = j;
      end
      if (found < 0) break;
      exp_own_q.push_back(found);
      do begin
        e = mq[found].pop_front();
        exp_q.push_back(e[7:0]);
      end while (!e[8]);
      m_ptr = (found + 1) % N;
    end
  endtask

  task automatic run_traffic(input int budget, input string name);
    int base, cyc, m_idx;
    logic [N-1:0] hs, er;
    logic [8:0] e;
    bit empty;
    exp_q.delete(); exp_own_q.delete(); obs_own_q.delete();
    base = got_q.size();
    build_expected();
    tx_auto = 1'b1;
    cyc = 0; m_idx = 0;
    drive_src();
    while (cyc < budget) begin
      er = '0;
      if (m_idx < exp_own_q.size()) er[exp_own_q[m_idx]] = 1'b1;
      if (req_ready != '0) begin
        total++;
        if (req_ready !== er) begin
          bad++;
          $display("FAIL %s ready_owner: req_ready=%b required=%b", name, req_ready, er);
        end
      end
      hs = req_valid & req_ready;
      step();
      for (int i = 0; i < N; i++) begin
        if (hs[i]) begin
          e = src_q[i].pop_front();
          if (e[8]) begin obs_own_q.push_back(i); m_idx++; end
        end
      end
      drive_src();
      cyc++;
      empty = 1'b1;
      for (int i = 0; i < N; i++) if (src_q[i].size() > 0) empty = 1'b0;
      if (empty && !busy) break;
    end
    tx_auto = 1'b0;
    step();
    total++;
    if (cyc >= budget) begin
      bad++;
      $display("FAIL %s budget: ran %0d cycles, required completion within %0d", name, cyc, budget);
    end
    total++;
    if (got_q.size() - base != exp_q.size()) begin
      bad++;
      $display("FAIL %s byte_count: got %0d required %0d", name, got_q.size() - base, exp_q.size());
    end
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base + k < got_q.size()) begin
        total++;
        if (got_q[base + k] !== exp_q[k]) begin
          bad++;
          $display("FAIL %s byte[%0d]: got %h required %h", name, k, got_q[base + k], exp_q[k]);
        end
      end
    end
    total++;
    if (obs_own_q.size() != exp_own_q.size()) begin
      bad++;
      $display("FAIL %s msg_count: got %0d required %0d", name, obs_own_q.size(), exp_own_q.size());
    end
    for (int k = 0; k < exp_own_q.size() && k < obs_own_q.size(); k++) begin
      total++;
      if (obs_own_q[k] != exp_own_q[k]) begin
        bad++;
        $display("FAIL %s owner[%0d]: got %0d required %0d", name, k, obs_own_q[k], exp_own_q[k]);
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset grant: got %b required 0000", grant); end
    total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL reset tx_req: got %b required 0", tx_req); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL reset tx_data: got %h required 00", tx_data); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b required 0", busy); end
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset req_ready: got %b required 0000", req_ready); end
    total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL reset state: got %0d required IDLE", state_dbg); end
  endtask

  task automatic test_single_byte();
    req_valid = 4'b0100; req_last = 4'b0100; req_data = '0; req_data[23:16] = 8'hA5;
    step();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL single grant: got %b required 0100", grant); end
    total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL single ready: got %b required 0100", req_ready); end
    total++; if (tx_req !== 1'b0) begin bad++; $display("FAIL single early_tx_req: got %b required 0", tx_req); end
    step();
    req_valid = '0;
    total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single ready_drop: got %b required 0000", req_ready); end
    total++; if ({tx_req, tx_data} !== {1'b1, 8'hA5}) begin bad++; $display("FAIL single load: got %b/%h required 1/a5", tx_req, tx_data); end
    for (int k = 0; k < 3; k++) begin
      req_data = 32'($urandom);
      step();
    end
    total++; if ({tx_req, tx_data} !== {1'b1, 8'hA5}) begin bad++; $display("FAIL single hold: got %b/%h required 1/a5", tx_req, tx_data); end
    pulse_started();
    total++; if ({busy, tx_req, grant} !== 6'b000000) begin bad++; $display("FAIL single release: busy/tx_req/grant got %b/%b/%b required 0/0/0000", busy, tx_req, grant); end
    // rr_ptr must now be 3: with 0 and 3 both valid, 3 wins.
    req_valid = 4'b1001; req_last = 4'b1001; req_data = 32'h3C00_0011;
    step();
    total++; if (grant !== 4'b1000) begin bad++; $display("FAIL single rr_ptr3: grant %b required 1000", grant); end
    step();
    req_valid = '0;
    pulse_started();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL single cleanup busy: got %b required 0", busy); end
    m_ptr = 0;
  endtask

  task automatic test_non_interleave();
    src_q[0].push_back({1'b0, 8'h48});
    src_q[0].push_back({1'b1, 8'h49});
    src_q[1].push_back({1'b1, 8'h58});
    run_traffic(200, "non_interleave");
  endtask

  task automatic test_round_robin();
    int want[5];
    do_reset();
    want = '{0, 1, 2, 3, 0};
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) src_q[i].push_back({1'b1, 8'(8'h10 * i + r)});
    run_traffic(400, "round_robin");
    for (int k = 0; k < 5; k++) begin
      if (k < obs_own_q.size()) begin
        total++;
        if (obs_own_q[k] != want[k]) begin bad++; $display("FAIL rr_order[%0d]: got %0d required %0d", k, obs_own_q[k], want[k]); end
      end
    end
  endtask

  task automatic test_random();
    int nmsg, len;
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < N; i++) begin
        nmsg = $urandom_range(0, 3);
        for (int m = 0; m < nmsg; m++) begin
          len = $urandom_range(1, 3);
          for (int b = 0; b < len; b++) src_q[i].push_back({(b == len - 1), 8'($urandom)});
        end
      end
      run_traffic(3000, "random");
    end
  endtask

  task automatic test_reset_in_load();
    req_valid = 4'b1010; req_last = 4'b1010; req_data = 32'($urandom);
    step(); step();
    total++; if (tx_req !== 1'b1) begin bad++; $display("FAIL rst_load setup tx_req: got %b required 1", tx_req); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++; if ({tx_req, busy, grant} !== 6'b000000) begin bad++; $display("FAIL rst_load clear: tx_req/busy/grant got %b/%b/%b required 0/0/0000", tx_req, busy, grant); end
    step();
    total++; if (grant !== 4'b0010) begin bad++; $display("FAIL rst_load rearb: grant %b required 0010", grant); end
    do_reset();
  endtask

  task automatic test_spurious();
    pulse_started();
    step();
    total++; if ({busy, tx_req, grant, tx_data} !== 14'b0) begin bad++; $display("FAIL spur_idle: busy/tx_req/grant/tx_data got %b/%b/%b/%h required all zero", busy, tx_req, grant, tx_data); end
    total++; if (state_dbg !== IDLE) begin bad++; $display("FAIL spur_idle state: got %0d required IDLE", state_dbg); end
    req_valid = 4'b0001; req_last = 4'b0000; req_data = 32'h0000_005A;
    step();
    req_valid = '0;
    pulse_started();
    total++; if ({busy, tx_req, grant, req_ready} !== {1'b1, 1'b0, 4'b0001, 4'b0001}) begin bad++; $display("FAIL spur_lock: busy/tx_req/grant/ready got %b/%b/%b/%b required 1/0/0001/0001", busy, tx_req, grant, req_ready); end
    total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL spur_lock tx_data: got %h required 00", tx_data); end
    req_valid = 4'b0001; req_last = 4'b0001;
    step();
    req_valid = '0;
    total++; if ({tx_req, tx_data} !== {1'b1, 8'h5A}) begin bad++; $display("FAIL spur_finish load: got %b/%h required 1/5a", tx_req, tx_data); end
    pulse_started();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL spur_finish busy: got %b required 0", busy); end
    m_ptr = 1;
  endtask

  task automatic test_lock_hold();
    do_reset();
    req_valid = 4'b0010; req_last = 4'b0000; req_data = 32'h0000_1100;
    step(); step();
    req_valid = '0;
    pulse_started();
`ifdef UART_TX_ARB_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      total++;
      if ({busy, grant} !== 5'b1_0010) begin bad++; $display("FAIL timeout lock[%0d]: busy/grant got %b/%b required 1/0010", k, busy, grant); end
      step();
    end
    total++; if ({busy, grant} !== 5'b0_0000) begin bad++; $display("FAIL timeout release: busy/grant got %b/%b required 0/0000", busy, grant); end
    req_valid = 4'b0101; req_last = 4'b0101;
    step();
    total++; if (grant !== 4'b0100) begin bad++; $display("FAIL timeout next: grant %b required 0100", grant); end
    do_reset();
`else
    for (int k = 0; k < 40; k++) begin
      total++;
      if ({busy, grant} !== 5'b1_0010) begin bad++; $display("FAIL lock_hold[%0d]: busy/grant got %b/%b required 1/0010", k, busy, grant); end
      step();
    end
    req_valid = 4'b0110; req_last = 4'b0110; req_data = 32'h0000_2200;
    step();
    req_valid = '0;
    total++; if ({tx_req, tx_data} !== {1'b1, 8'h22}) begin bad++; $display("FAIL lock_hold resume: got %b/%h required 1/22", tx_req, tx_data); end
    pulse_started();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL lock_hold release busy: got %b required 0", busy); end
    do_reset();
`endif
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    rst = 1'b1; man_pulse = 1'b0; tx_auto = 1'b0;
    req_valid = '0; req_last = '0; req_data = '0;
    test_reset();
    test_single_byte();
    test_non_interleave();
    test_round_robin();
    test_random();
    test_reset_in_load();
    test_spurious();
    test_lock_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 Parameter: NREQ, default 4, number of byte-stream requesters (2..8).
REQ-002 Parameter: TIMEOUT, default 1024, idle-owner lock timeout in clk cycles (timeout build only).
REQ-003 Port: clk  in  1  single clock; all logic on posedge.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: req_valid  in  NREQ  requester i presents a byte.
REQ-006 Port: req_data  in  8*NREQ  byte of requester i at bits [8i+7:8i].
REQ-007 Port: req_last  in  NREQ  presented byte ends requester i's message.
REQ-008 Port: req_ready  out  NREQ  arbiter accepts requester i's byte this cycle.
REQ-009 Port: tx_req  out  1  holding byte valid; drives the UART transmitter's queue-not-empty input.
REQ-010 Port: tx_data  out  8  holding byte to the transmitter.
REQ-011 Port: tx_started  in  1  one-cycle pulse: transmitter latched tx_data.
REQ-012 Port: grant  out  NREQ  one-hot current message owner; zero when none.
REQ-013 Port: busy  out  1  high whenever state is not IDLE.

Function
REQ-014 States: IDLE (no owner), LOCK (owner set, holding empty), LOAD (holding full, tx_req=1).
REQ-015 IDLE: if any req_valid, pick the first set bit at or after rr_ptr (wrap modulo NREQ); owner and grant are registered; next state LOCK. Arbitration latency is 1 cycle.
REQ-016 IDLE with no req_valid: stay IDLE; grant=0.
REQ-017 req_ready[i] is combinational: 1 only for i==owner in LOCK; 0 in IDLE and LOAD.
REQ-018 A transfer occurs when req_valid[owner] and req_ready[owner] are both high: tx_data, last_q are captured and the next state is LOAD.
REQ-019 LOAD: tx_req=1 and tx_data is held stable until tx_started.
REQ-020 LOAD with tx_started and last_q=0: go to LOCK, owner unchanged.
REQ-021 LOAD with tx_started and last_q=1: go to IDLE; rr_ptr <= owner+1 (wraps NREQ-1 to 0); grant cleared.
REQ-022 Messages never interleave: no other requester gets req_ready until the owner's last byte has been started.
REQ-023 tx_started outside LOAD is ignored; there is no state change and no error.
REQ-024 A single requester streaming back-to-back gets at most one byte per transmitter frame; no byte is dropped or duplicated.
REQ-025 A requester dropping req_valid in LOCK keeps its lock; it is not released except per REQ-030.

Reset
REQ-026 On rst: state=IDLE, rr_ptr=0, grant=0, tx_req=0, tx_data=8'h00, last_q=0, req_ready=0, busy=0, timeout counter=0.
REQ-027 Reset mid-message discards the holding byte and the lock; the first post-reset arbitration starts from requester 0.

Configuration
REQ-028 Macro UART_TX_ARB_TIMEOUT_EN compiles in the lock timeout.
REQ-029 With the macro, the counter clears on entering LOCK and on each transfer, and increments every LOCK cycle without a transfer.
REQ-030 With the macro, when the counter reaches TIMEOUT-1 in LOCK: go to IDLE, rr_ptr <= owner+1, grant cleared, and the partial message is abandoned.
REQ-031 Without the macro, no counter exists and LOCK is held indefinitely.

Structure
REQ-032 Package uart_tx_arb_pkg holds the state enum arb_state_t {IDLE, LOCK, LOAD} and the default constants NREQ_DEF=4 and TIMEOUT_DEF=1024.
REQ-033 Sub-module rr_pick (combinational: req vector, pointer -> one-hot pick, any) is the only child module.

Verification
REQ-034 Single byte: req_valid[2]=1, data 8'hA5, last=1. Required: grant=4'b0100 one cycle later; req_ready[2] for 1 cycle; then tx_req=1, tx_data=A5; on tx_started the block returns to IDLE and rr_ptr=3.
REQ-035 Non-interleave: req0 sends "HI" (last on I) while req1 is valid throughout. Required: tx order H, I, then req1's byte; req_ready[1]=0 until I is started.
REQ-036 Round-robin: all 4 requesters hold single-byte messages continuously. Required: grant order 0,1,2,3,0; no requester served twice before the others are served.
REQ-037 Reset in LOAD: assert rst with tx_req=1. Required: next cycle tx_req=0, grant=0, busy=0; the next arbitration picks the lowest valid index.
REQ-038 Timeout (macro set, TIMEOUT=16): owner 1 sends a non-last byte, then drops valid. Required: 16 LOCK cycles, then IDLE with grant=0, and requester 2 is granted next.
REQ-039 Spurious tx_started pulses in IDLE and LOCK. Required: no state or output change.
